// File: rtl/cmd_serializer_if.sv
// Command input port of cmd_serializer: valid/ready handshake carrying one command word.
//   valid   : producer presents data_in
//   ready   : serializer FIFO can accept a word this cycle
//   data_in : LENGTH-bit command word
interface cmd_serializer_if #(
    parameter int unsigned LENGTH = 32
);
    logic              valid;
    logic              ready;
    logic [LENGTH-1:0] data_in;

    modport master (output valid, output data_in, input ready);
    modport slave  (input valid, input data_in, output ready);
endinterface

// File: rtl/cmd_serializer.sv
// Buffered serial command transmitter. Words accepted on a valid/ready port are queued in
// a DEPTH-entry FIFO and sent as framed bursts over LINES lines:
// start (all ones), BPL data cycles MSB first, optional even-parity cycle, GAP low cycles.
//   clk   : rising-edge clock
//   rst   : synchronous active-low reset
//   bus   : command port (valid, ready, data_in), slave side
//   d     : serial lines, registered
//   busy  : frame in progress or words queued
//   level : FIFO occupancy
module cmd_serializer #(
    parameter int unsigned LENGTH = 32,
    parameter int unsigned LINES  = 1,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PARITY = 0,
    parameter int unsigned GAP    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    cmd_serializer_if.slave            bus,
    output logic [LINES-1:0]           d,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int unsigned BPL  = LENGTH / LINES;
    localparam int unsigned LW   = $clog2(DEPTH + 1);
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CMAX = (BPL > GAP) ? BPL : GAP;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    // Parameter sanity, caught at elaboration
    if ((LENGTH % LINES) != 0) begin : g_bad_lines
        $error("cmd_serializer: LENGTH must be a multiple of LINES");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("cmd_serializer: DEPTH must be >= 1");
    end
    if (GAP < 1) begin : g_bad_gap
        $error("cmd_serializer: GAP must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [LENGTH-1:0] shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LINES-1:0]  par_q, par_d;
    logic [LINES-1:0]  d_q, d_d;
    logic              busy_q, busy_d;
    logic [LW-1:0]     level_q, level_d;
    logic              ready_q, ready_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LENGTH-1:0] mem_q [DEPTH];
    logic [LENGTH-1:0] head;
    logic [LINES-1:0]  top;
    logic              push;
    logic              pop;

    assign head      = mem_q[rd_ptr_q];
    assign top       = shift_q[LENGTH-1 -: LINES];
    assign push      = bus.valid && ready_q;
    assign bus.ready = ready_q;
    assign d         = d_q;
    assign busy      = busy_q;
    assign level     = level_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // FIFO pointers, occupancy and registered ready
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        level_d = level_q + LW'(push) - LW'(pop);
        ready_d = (level_d != LW'(DEPTH));
    end

    // Frame sequencer; d_d is the line value for the cycle entered on the next edge.
    // The final GAP cycle pops directly into START so back-to-back frames have no idle cycle.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        d_d     = '0;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    d_d     = '1;
                    state_d = S_START;
                end
            end
            S_START: begin
                d_d     = top;
                par_d   = top;
                shift_d = shift_q << LINES;
                cnt_d   = '0;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (cnt_q == CW'(BPL - 1)) begin
                    cnt_d = '0;
                    if (PARITY != 0) begin
                        d_d     = par_q;
                        state_d = S_PARITY;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    d_d     = top;
                    par_d   = par_q ^ top;
                    shift_d = shift_q << LINES;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            S_PARITY: begin
                cnt_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (cnt_q == CW'(GAP - 1)) begin
                    cnt_d = '0;
                    if (level_q != '0) begin
                        pop     = 1'b1;
                        shift_d = head;
                        d_d     = '1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Busy covers the frame being sent and anything still queued
    always_comb begin
        busy_d = (state_d != S_IDLE) || (level_d != '0);
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            par_q    <= '0;
            d_q      <= '0;
            busy_q   <= 1'b0;
            level_q  <= '0;
            ready_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
            d_q      <= d_d;
            busy_q   <= busy_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage, no reset needed: pointers define validity
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end
endmodule

// File: tb/tb_cmd_serializer.sv
// Bench for cmd_serializer: three configurations share one stimulus stream and are checked
// every cycle against a frame-position reference model, plus directed spot checks.
module tb_cmd_serializer;
    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [31:0] data_in;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cmd_serializer_if #(.LENGTH(32)) bus0 ();
    cmd_serializer_if #(.LENGTH(32)) bus1 ();
    cmd_serializer_if #(.LENGTH(32)) bus2 ();

    assign bus0.valid   = valid;
    assign bus0.data_in = data_in;
    assign bus1.valid   = valid;
    assign bus1.data_in = data_in;
    assign bus2.valid   = valid;
    assign bus2.data_in = data_in;

    logic [0:0] d0;
    logic [3:0] d1;
    logic [0:0] d2;
    logic       busy0, busy1, busy2;
    logic [2:0] level0;
    logic [1:0] level1, level2;

    cmd_serializer #(.LENGTH(32), .LINES(1), .DEPTH(4), .PARITY(0), .GAP(2)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .d(d0), .busy(busy0), .level(level0)
    );
    cmd_serializer #(.LENGTH(32), .LINES(4), .DEPTH(3), .PARITY(1), .GAP(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .d(d1), .busy(busy1), .level(level1)
    );
    cmd_serializer #(.LENGTH(32), .LINES(1), .DEPTH(2), .PARITY(1), .GAP(3)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .d(d2), .busy(busy2), .level(level2)
    );

    // Configuration of each instance
    function automatic int lines_of(int i);
        return (i == 1) ? 4 : 1;
    endfunction
    function automatic int depth_of(int i);
        case (i)
            0:       return 4;
            1:       return 3;
            default: return 2;
        endcase
    endfunction
    function automatic int par_of(int i);
        return (i == 0) ? 0 : 1;
    endfunction
    function automatic int gap_of(int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 3;
        endcase
    endfunction
    function automatic int period_of(int i);
        return 1 + 32 / lines_of(i) + par_of(i) + gap_of(i);
    endfunction

    // DUT observation
    function automatic logic [31:0] dut_d(int i);
        case (i)
            0:       return 32'(d0);
            1:       return 32'(d1);
            default: return 32'(d2);
        endcase
    endfunction
    function automatic logic [31:0] dut_busy(int i);
        case (i)
            0:       return 32'(busy0);
            1:       return 32'(busy1);
            default: return 32'(busy2);
        endcase
    endfunction
    function automatic logic [31:0] dut_level(int i);
        case (i)
            0:       return 32'(level0);
            1:       return 32'(level1);
            default: return 32'(level2);
        endcase
    endfunction
    function automatic logic [31:0] dut_ready(int i);
        case (i)
            0:       return 32'(bus0.ready);
            1:       return 32'(bus1.ready);
            default: return 32'(bus2.ready);
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: a word queue plus the position inside the frame being sent (-1 = idle)
    logic [31:0] mfifo [NI][16];
    int          mhead [NI];
    int          mcnt  [NI];
    int          mpos  [NI];
    logic [31:0] mcur  [NI];
    logic        mready[NI];

    // Line value at frame position pos: d bit k carries word bits 32-L+k, 32-L+k-L, ...
    function automatic logic [31:0] frame_d(int i, logic [31:0] w, int pos);
        int          ln;
        int          bpl;
        logic [31:0] r;
        logic [31:0] x;
        ln  = lines_of(i);
        bpl = 32 / ln;
        r   = '0;
        if (pos == 0) begin
            r = (32'd1 << ln) - 32'd1;
        end else if (pos <= bpl) begin
            for (int k = 0; k < ln; k++) begin
                r |= ((w >> (32 - ln + k - (pos - 1) * ln)) & 32'd1) << k;
            end
        end else if (pos == bpl + 1 && par_of(i) == 1) begin
            for (int k = 0; k < ln; k++) begin
                x = '0;
                for (int m = 0; m < bpl; m++) begin
                    x ^= (w >> (32 - ln + k - m * ln)) & 32'd1;
                end
                r |= x << k;
            end
        end
        return r;
    endfunction

    task automatic model_edge(int i, logic r, logic v, logic [31:0] w);
        logic can_push;
        if (!r) begin
            mhead[i]  = 0;
            mcnt[i]   = 0;
            mpos[i]   = -1;
            mready[i] = 1'b0;
        end else begin
            can_push = mready[i] && v;
            if (mpos[i] >= 0) begin
                mpos[i]++;
                if (mpos[i] == period_of(i)) mpos[i] = -1;
            end
            if (mpos[i] == -1 && mcnt[i] > 0) begin
                mcur[i]  = mfifo[i][mhead[i]];
                mhead[i] = (mhead[i] + 1) % 16;
                mcnt[i]--;
                mpos[i]  = 0;
            end
            if (can_push) begin
                mfifo[i][(mhead[i] + mcnt[i]) % 16] = w;
                mcnt[i]++;
            end
            mready[i] = (mcnt[i] != depth_of(i));
        end
    endtask

    task automatic compare_all();
        logic [31:0] ed;
        for (int i = 0; i < NI; i++) begin
            ed = (mpos[i] >= 0) ? frame_d(i, mcur[i], mpos[i]) : 32'd0;
            check_eq($sformatf("d%0d", i), dut_d(i), ed);
            check_eq($sformatf("busy%0d", i), dut_busy(i), 32'((mpos[i] >= 0) || (mcnt[i] > 0)));
            check_eq($sformatf("level%0d", i), dut_level(i), 32'(mcnt[i]));
            check_eq($sformatf("ready%0d", i), dut_ready(i), 32'(mready[i]));
        end
    endtask

    // One clock: model sees the inputs present at the edge, outputs sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < NI; i++) model_edge(i, rst, valid, data_in);
        #1;
        compare_all();
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < NI; i++) begin
            if (mpos[i] >= 0 || mcnt[i] > 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        while (!all_idle() && n < 300) begin
            tick();
            n++;
        end
        check_eq("drain_done", 32'(all_idle()), 32'd1);
    endtask

    task automatic push_one(logic [31:0] w);
        valid   = 1'b1;
        data_in = w;
        tick();
        valid   = 1'b0;
        data_in = $urandom;
    endtask

    logic [3:0] exp2 [8];
    int         waited;

    initial begin
        exp2 = '{4'hF, 4'h0, 4'hB, 4'h4, 4'h0, 4'h4, 4'h1, 4'h1};
        for (int i = 0; i < NI; i++) begin
            mhead[i]  = 0;
            mcnt[i]   = 0;
            mpos[i]   = -1;
            mcur[i]   = '0;
            mready[i] = 1'b0;
        end
        rst     = 1'b0;
        valid   = 1'b0;
        data_in = '0;

        // Reset state
        repeat (3) tick();
        check_eq("rst_ready0", dut_ready(0), 32'd0);
        check_eq("rst_level0", dut_level(0), 32'd0);
        rst = 1'b1;
        tick();
        check_eq("ready_after_rst", dut_ready(0), 32'd1);
        repeat (3) tick();

        // Single word, one line, no parity: start, 1111, 28 zeros, 2 gap
        push_one(32'hF000_0000);
        check_eq("t1_busy_push", dut_busy(0), 32'd1);
        check_eq("t1_d_push", dut_d(0), 32'd0);
        for (int k = 1; k <= 36; k++) begin
            tick();
            check_eq($sformatf("t1_d_k%0d", k), dut_d(0), 32'((k >= 1 && k <= 5) ? 1 : 0));
            if (k == 35) check_eq("t1_busy_last_gap", dut_busy(0), 32'd1);
            if (k == 36) check_eq("t1_busy_end", dut_busy(0), 32'd0);
        end
        drain();

        // Four lines with parity
        push_one(32'hF0B4_0411);
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 1) check_eq("t2_start", dut_d(1), 32'hF);
            if (k >= 2 && k <= 9) check_eq($sformatf("t2_data_k%0d", k), dut_d(1), 32'(exp2[k-2]));
            if (k == 10) check_eq("t2_parity", dut_d(1), 32'h4);
            if (k == 11) check_eq("t2_gap", dut_d(1), 32'h0);
        end
        drain();

        // One line with parity: odd and even bit counts
        push_one(32'h0000_0007);
        for (int k = 1; k <= 34; k++) begin
            tick();
            if (k == 34) check_eq("t4_parity_odd", dut_d(2), 32'd1);
        end
        drain();
        push_one(32'h0000_0003);
        for (int k = 1; k <= 34; k++) begin
            tick();
            if (k == 34) check_eq("t4_parity_even", dut_d(2), 32'd0);
        end
        drain();

        // Back-to-back pushes fill the DEPTH=4 FIFO; a further word is dropped
        for (int n = 0; n < 6; n++) begin
            valid   = 1'b1;
            data_in = 32'hA5C3_0000 + 32'(n * 32'h1111);
            tick();
            if (n == 4) begin
                check_eq("t3_level_full", dut_level(0), 32'd4);
                check_eq("t3_ready_full", dut_ready(0), 32'd0);
            end
        end
        valid = 1'b0;
        drain();

        // Reset mid-DATA with two words queued
        for (int n = 0; n < 3; n++) push_one(32'h8000_0001 + 32'(n));
        repeat (8) tick();
        check_eq("t5_queued", dut_level(0), 32'd2);
        rst = 1'b0;
        tick();
        check_eq("t5_d", dut_d(0), 32'd0);
        check_eq("t5_level", dut_level(0), 32'd0);
        check_eq("t5_busy", dut_busy(0), 32'd0);
        rst = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick();
            check_eq("t5_quiet", dut_d(0), 32'd0);
        end

        // Push coinciding with pop at level 3
        for (int n = 0; n < 4; n++) push_one(32'h1234_5670 + 32'(n));
        waited = 0;
        while (!(mpos[0] == period_of(0) - 1 && mcnt[0] == 3) && waited < 60) begin
            tick();
            waited++;
        end
        check_eq("t6_reached", 32'(waited < 60), 32'd1);
        push_one(32'hDEAD_BEEF);
        check_eq("t6_level", dut_level(0), 32'd3);
        check_eq("t6_ready", dut_ready(0), 32'd1);
        drain();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            valid   = ($urandom_range(0, 99) < ((c < 1500) ? 70 : 25));
            data_in = $urandom;
            rst     = ($urandom_range(0, 599) != 0);
            tick();
        end
        rst   = 1'b1;
        valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
